// File: rtl/uart_rx_parity.sv
// UART receiver: 2-flop input synchronizer, 16x-oversampled frame FSM with
// optional parity, and registered byte/flag outputs qualified by rx_done_tick.
module uart_rx_parity #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int SW = (SB_TICK > 16) ? 5 : 4;

    localparam logic [SW-1:0] START_LAST = SW'(7);
    localparam logic [SW-1:0] BIT_LAST   = SW'(15);
    localparam logic [SW-1:0] STOP_LAST  = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST     = 3'(DBIT - 1);
    localparam logic          PAR_EN     = (PARITY_EN != 0);
    localparam logic          PAR_ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic          r_rx_meta;
    logic          r_rx_s;

    state_t        r_state;
    logic [SW-1:0] r_s_cnt;
    logic [2:0]    r_n_cnt;
    logic [7:0]    r_b;
    logic          r_p_acc;
    logic          r_p_bad;
    logic [7:0]    r_dout;
    logic          r_done;
    logic          r_perr;
    logic          r_ferr;

    state_t        w_state_next;
    logic [SW-1:0] w_s_cnt_next;
    logic [2:0]    w_n_cnt_next;
    logic [7:0]    w_b_next;
    logic          w_p_acc_next;
    logic          w_p_bad_next;
    logic [7:0]    w_dout_next;
    logic          w_done_next;
    logic          w_perr_next;
    logic          w_ferr_next;
    logic [7:0]    w_dout_aligned;

    // rx is asynchronous; idle-high reset keeps a reset release from looking like a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Bits enter at the MSB, so a short word sits in the top DBIT bits of r_b
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_align
            if (gi < DBIT) begin : g_bit
                assign w_dout_aligned[gi] = r_b[gi + 8 - DBIT];
            end else begin : g_zero
                assign w_dout_aligned[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_b     <= '0;
            r_p_acc <= 1'b0;
            r_p_bad <= 1'b0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s_cnt <= w_s_cnt_next;
            r_n_cnt <= w_n_cnt_next;
            r_b     <= w_b_next;
            r_p_acc <= w_p_acc_next;
            r_p_bad <= w_p_bad_next;
            r_dout  <= w_dout_next;
            r_done  <= w_done_next;
            r_perr  <= w_perr_next;
            r_ferr  <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        w_n_cnt_next = r_n_cnt;
        w_b_next     = r_b;
        w_p_acc_next = r_p_acc;
        w_p_bad_next = r_p_bad;
        w_dout_next  = r_dout;
        w_done_next  = 1'b0;
        w_perr_next  = r_perr;
        w_ferr_next  = r_ferr;

        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                    w_s_cnt_next = '0;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (r_s_cnt == START_LAST) begin
                        if (!r_rx_s) begin
                            w_state_next = ST_DATA;
                            w_s_cnt_next = '0;
                            w_n_cnt_next = '0;
                            w_p_acc_next = 1'b0;
                            w_p_bad_next = 1'b0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + SW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (r_s_cnt == BIT_LAST) begin
                        w_s_cnt_next = '0;
                        w_b_next     = {r_rx_s, r_b[7:1]};
                        w_p_acc_next = r_p_acc ^ r_rx_s;
                        if (r_n_cnt == N_LAST) begin
                            w_state_next = PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            w_n_cnt_next = r_n_cnt + 3'd1;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + SW'(1);
                    end
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s_cnt == BIT_LAST) begin
                        w_s_cnt_next = '0;
                        w_p_bad_next = PAR_EN & (r_rx_s ^ r_p_acc ^ PAR_ODD);
                        w_state_next = ST_STOP;
                    end else begin
                        w_s_cnt_next = r_s_cnt + SW'(1);
                    end
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (r_s_cnt == STOP_LAST) begin
                        // Errored frames are still delivered; the flags qualify them
                        w_done_next  = 1'b1;
                        w_dout_next  = w_dout_aligned;
                        w_perr_next  = r_p_bad;
                        w_ferr_next  = ~r_rx_s;
                        w_s_cnt_next = '0;
                        w_n_cnt_next = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_s_cnt_next = r_s_cnt + SW'(1);
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign parity_err   = r_perr;
    assign frame_err    = r_ferr;

endmodule
